// File: rtl/game_pkg.sv
// Shared definitions for the game controller: state encoding, BCD helpers and
// screen/dinosaur constants used by the control path and the display path.
package game_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_OVER    = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RUNNING = ST_RUNNING,
        OVER    = ST_OVER
    } game_state_t;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [5:0] GROUND_HEIGHT = 6'h3F;
    localparam int         SCREEN_W      = 640;

    // Ripple a +1 through four BCD digits, least significant digit first.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
                    r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
                end else begin
                    r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = r[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_ctrl_bcd_counter4.sv
// Four-digit BCD counter with synchronous clear and increment that sticks at 9999.
module bcd_counter4
    import game_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q <= 16'h0000;
        end else if (clr) begin
            q <= 16'h0000;
        end else if (inc && (q != 16'h9999)) begin
            q <= bcd_inc(q);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing: button synchroniser, start/collision/restart FSM, score divider,
// restart holdoff and high-score register.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DINO_X_LO    = 40,
    parameter int DINO_X_HI    = 60,
    parameter int OBST_W       = 10,
    parameter int CLEAR_HEIGHT = 50,
    parameter int SCORE_DIV    = 6,
    parameter int HOLDOFF      = 30
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        tick,
    input  logic        button_jump,
    input  logic [5:0]  dinosaur_height,
    input  logic [9:0]  obstacle_x,
    input  logic        obstacle_valid,
    output logic        game_status,
    output logic        game_over,
    output logic        start_pulse,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd
);

    game_state_t state;
    logic        btn_meta;
    logic        btn_sync;
    logic        btn_prev;
    logic        btn_rise;
    logic [2:0]  div;
    logic [4:0]  holdoff;
    logic [10:0] obst_right;
    logic        collide;
    logic        score_clr;
    logic        score_inc;

    // btn_rise is registered so the pin-to-pulse latency is three clocks.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
            btn_rise <= 1'b0;
        end else begin
            btn_meta <= button_jump;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            btn_rise <= btn_sync & ~btn_prev;
        end
    end

    assign obst_right = {1'b0, obstacle_x} + 11'(OBST_W);
    assign collide    = obstacle_valid
                     && (obstacle_x <= 10'(DINO_X_HI))
                     && (obst_right > 11'(DINO_X_LO))
                     && (dinosaur_height >= 6'(CLEAR_HEIGHT));

    always_comb begin
        score_clr = 1'b0;
        score_inc = 1'b0;
        case (state)
            IDLE:    score_clr = 1'b1;
            RUNNING: score_inc = tick && !collide && (div == 3'(SCORE_DIV - 1));
            OVER:    score_clr = btn_rise && (holdoff == 5'd0);
            default: score_clr = 1'b1;
        endcase
    end

    bcd_counter4 u_score (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (score_clr),
        .inc   (score_inc),
        .q     (score_bcd)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            div         <= 3'd0;
            holdoff     <= 5'd0;
            high_bcd    <= 16'h0000;
            game_status <= 1'b0;
            game_over   <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    div <= 3'd0;
                    if (btn_rise) begin
                        state       <= RUNNING;
                        start_pulse <= 1'b1;
                        game_status <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (tick) begin
                        if (collide) begin
                            state       <= OVER;
                            holdoff     <= 5'(HOLDOFF);
                            game_status <= 1'b0;
                            game_over   <= 1'b1;
                            if (score_bcd > high_bcd) begin
                                high_bcd <= score_bcd;
                            end
                        end else if (div == 3'(SCORE_DIV - 1)) begin
                            div <= 3'd0;
                        end else begin
                            div <= div + 3'd1;
                        end
                    end
                end
                OVER: begin
                    // A press during holdoff is dropped outright, never remembered.
                    if (btn_rise && (holdoff == 5'd0)) begin
                        state       <= RUNNING;
                        start_pulse <= 1'b1;
                        game_status <= 1'b1;
                        game_over   <= 1'b0;
                        div         <= 3'd0;
                    end else if (tick && (holdoff != 5'd0)) begin
                        holdoff <= holdoff - 5'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    game_status <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl: start latency, scoring, hitbox edges,
// restart holdoff, score saturation and asynchronous reset.
module tb_game_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        tick;
    logic        button_jump;
    logic [5:0]  dinosaur_height;
    logic [9:0]  obstacle_x;
    logic        obstacle_valid;
    logic        game_status;
    logic        game_over;
    logic        start_pulse;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;

    int tests_run;
    int tests_failed;

    game_ctrl dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .tick            (tick),
        .button_jump     (button_jump),
        .dinosaur_height (dinosaur_height),
        .obstacle_x      (obstacle_x),
        .obstacle_valid  (obstacle_valid),
        .game_status     (game_status),
        .game_over       (game_over),
        .start_pulse     (start_pulse),
        .score_bcd       (score_bcd),
        .high_bcd        (high_bcd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cycle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_tick(input int n);
        tick = 1'b1;
        cycle(n);
        tick = 1'b0;
    endtask

    task automatic apply_stimulus_press();
        button_jump = 1'b1;
        cycle(5);
        button_jump = 1'b0;
        cycle(3);
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        RST_N           = 1'b0;
        tick            = 1'b0;
        button_jump     = 1'b0;
        dinosaur_height = 6'h3F;
        obstacle_x      = 10'd0;
        obstacle_valid  = 1'b0;
        cycle(3);

        check_output("rst_status", 16'(game_status), 16'h0);
        check_output("rst_over",   16'(game_over),   16'h0);
        check_output("rst_start",  16'(start_pulse), 16'h0);
        check_output("rst_score",  score_bcd,        16'h0000);
        check_output("rst_high",   high_bcd,         16'h0000);
        RST_N = 1'b1;
        cycle(1);

        // Start: three clocks to btn_rise, state registered on the fourth.
        button_jump = 1'b1;
        cycle(3);
        check_output("start_status_c3", 16'(game_status), 16'h0);
        check_output("start_pulse_c3",  16'(start_pulse), 16'h0);
        cycle(1);
        check_output("start_status_c4", 16'(game_status), 16'h1);
        check_output("start_pulse_c4",  16'(start_pulse), 16'h1);
        cycle(1);
        button_jump = 1'b0;
        check_output("start_pulse_c5",  16'(start_pulse), 16'h0);
        check_output("start_status_c5", 16'(game_status), 16'h1);
        cycle(3);

        apply_tick(60);
        check_output("score_60",      score_bcd,        16'h0010);
        check_output("status_run_60", 16'(game_status), 16'h1);

        obstacle_valid  = 1'b1;
        obstacle_x      = 10'd50;
        dinosaur_height = 6'd20;
        apply_tick(1);
        check_output("high_jump_nohit", 16'(game_status), 16'h1);
        dinosaur_height = 6'h3F;
        obstacle_x      = 10'd30;
        apply_tick(1);
        check_output("x30_nohit", 16'(game_status), 16'h1);
        obstacle_x = 10'd61;
        apply_tick(1);
        check_output("x61_nohit",      16'(game_status), 16'h1);
        check_output("score_pre_hit",  score_bcd,        16'h0010);

        obstacle_x = 10'd50;
        apply_tick(1);
        check_output("x50_over",   16'(game_over),   16'h1);
        check_output("x50_status", 16'(game_status), 16'h0);
        check_output("x50_high",   high_bcd,         16'h0010);
        check_output("x50_score",  score_bcd,        16'h0010);

        apply_tick(10);
        apply_stimulus_press();
        check_output("holdoff_press_over",   16'(game_over),   16'h1);
        check_output("holdoff_press_status", 16'(game_status), 16'h0);
        apply_tick(25);
        button_jump = 1'b1;
        cycle(4);
        check_output("restart_status", 16'(game_status), 16'h1);
        check_output("restart_pulse",  16'(start_pulse), 16'h1);
        check_output("restart_over",   16'(game_over),   16'h0);
        check_output("restart_score",  score_bcd,        16'h0000);
        check_output("restart_high",   high_bcd,         16'h0010);
        cycle(1);
        button_jump = 1'b0;
        cycle(3);

        obstacle_x = 10'd31;
        apply_tick(1);
        check_output("x31_hit",  16'(game_over), 16'h1);
        check_output("x31_high", high_bcd,       16'h0010);
        apply_tick(30);
        apply_stimulus_press();
        check_output("restart2_status", 16'(game_status), 16'h1);

        obstacle_x = 10'd60;
        apply_tick(1);
        check_output("x60_hit", 16'(game_over), 16'h1);
        apply_tick(30);
        apply_stimulus_press();
        check_output("restart3_status", 16'(game_status), 16'h1);

        obstacle_valid = 1'b0;
        apply_tick(59988);
        check_output("score_9998", score_bcd, 16'h9998);
        apply_tick(12);
        check_output("score_sat_9999", score_bcd,        16'h9999);
        check_output("sat_status",     16'(game_status), 16'h1);

        // Reset asserted between clock edges must clear outputs without waiting for CLK.
        #2;
        RST_N = 1'b0;
        #1;
        check_output("async_status", 16'(game_status), 16'h0);
        check_output("async_over",   16'(game_over),   16'h0);
        check_output("async_start",  16'(start_pulse), 16'h0);
        check_output("async_score",  score_bcd,        16'h0000);
        check_output("async_high",   high_bcd,         16'h0000);
        cycle(1);
        RST_N = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
